spiflash_cmd_ctrl: RTL

- Command sequencer behind the SPI byte-level device interface in the SPI flash simulator.
- Decodes the opcode and address bytes delivered on the rx strobe. Fetches array bytes from a synchronous read-only memory port. Supplies the next MISO byte on the tx data/strobe pair.
- Supported commands: READ 0x03, FAST_READ 0x0B, RDSR 0x05, RDID 0x9F, WREN 0x06, WRDI 0x04. Any other opcode is ignored until chip deselect.

---
 rtl/spiflash_cmd_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/spiflash_cmd_ctrl.sv
// SPI flash command sequencer: decodes opcode/address bytes from the SPI byte
// interface, reads the array through a 1-cycle ROM port and supplies MISO bytes.
module spiflash_cmd_ctrl #(
  parameter int          MEM_AW    = 16,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016,
  parameter bit          ID_REPEAT = 1'b1
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_rx_strobe,
  input  logic [7:0]        spi_rx_data,
  output logic              spi_tx_strobe,
  output logic [7:0]        spi_tx_data,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              wel,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Handshake: spi_rx_strobe is a one-cycle valid with no back-pressure; the
  // tx pair is a level (strobe high = spi_tx_data is the next MISO byte), and
  // mem_rdata is valid exactly one cycle after a mem_rd_en pulse.

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DUMMY  = 3'd2,
    ST_DATA   = 3'd3,
    ST_STATUS = 3'd4,
    ST_ID     = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_FAST  = 8'h0B;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_RDID  = 8'h9F;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;

  state_t            state, state_next;
  logic [MEM_AW-1:0] addr;
  logic [MEM_AW-1:0] addr_shift;
  logic [1:0]        byte_cnt;
  logic              fast;
  logic [1:0]        id_idx;
  logic [7:0]        pf_data;
  logic              pf_valid;
  logic              mem_first;
  logic              rd_wait;
  logic              rd_first;
  logic              issue_fetch;
  logic [MEM_AW-1:0] fetch_addr;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
  endfunction

  // Only the low MEM_AW bits of the 24-bit SPI address are ever kept.
  assign addr_shift = MEM_AW'({addr, spi_rx_data});

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge mclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    issue_fetch = 1'b0;
    fetch_addr  = addr;
    if (spi_cs) begin
      state_next = ST_IDLE;
    end else begin
      if (spi_rx_strobe) begin
        case (state)
          ST_IDLE: begin
            case (spi_rx_data)
              OP_READ, OP_FAST: state_next = ST_ADDR;
              OP_RDSR:          state_next = ST_STATUS;
              OP_RDID:          state_next = ST_ID;
              default:          state_next = ST_IGNORE;
            endcase
          end
          ST_ADDR: begin
            if (byte_cnt == 2'd2) begin
              if (fast) begin
                state_next = ST_DUMMY;
              end else begin
                state_next  = ST_DATA;
                issue_fetch = 1'b1;
                fetch_addr  = addr_shift;
              end
            end
          end
          ST_DUMMY: begin
            state_next  = ST_DATA;
            issue_fetch = 1'b1;
          end
          ST_DATA:  issue_fetch = 1'b1;
          default: ;
        endcase
      end
      // The first byte of a burst lands in tx; immediately queue the prefetch.
      if (state == ST_DATA && rd_wait && rd_first) issue_fetch = 1'b1;
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      spi_tx_strobe <= 1'b0;
      spi_tx_data   <= 8'hFF;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      wel           <= 1'b0;
      addr          <= '0;
      byte_cnt      <= 2'd0;
      fast          <= 1'b0;
      id_idx        <= 2'd0;
      pf_data       <= 8'h00;
      pf_valid      <= 1'b0;
      mem_first     <= 1'b0;
      rd_wait       <= 1'b0;
      rd_first      <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      rd_wait   <= mem_rd_en;
      rd_first  <= mem_first;
      if (spi_cs) begin
        spi_tx_strobe <= 1'b0;
        spi_tx_data   <= 8'hFF;
        pf_valid      <= 1'b0;
        rd_wait       <= 1'b0;
      end else begin
        if (spi_rx_strobe) begin
          case (state)
            ST_IDLE: begin
              case (spi_rx_data)
                OP_READ, OP_FAST: begin
                  byte_cnt <= 2'd0;
                  fast     <= (spi_rx_data == OP_FAST);
                end
                OP_RDSR: begin
                  spi_tx_data   <= {6'b0, wel, 1'b0};
                  spi_tx_strobe <= 1'b1;
                end
                OP_RDID: begin
                  spi_tx_data   <= id_byte(2'd0);
                  spi_tx_strobe <= 1'b1;
                  id_idx        <= 2'd0;
                end
                OP_WREN: wel <= 1'b1;
                OP_WRDI: wel <= 1'b0;
                default: ;
              endcase
            end
            ST_ADDR: begin
              addr     <= addr_shift;
              byte_cnt <= byte_cnt + 2'd1;
            end
            ST_DATA: begin
              spi_tx_data <= pf_valid ? pf_data : 8'hFF;
              pf_valid    <= 1'b0;
            end
            ST_STATUS: spi_tx_data <= {6'b0, wel, 1'b0};
            ST_ID: begin
              if (id_idx == 2'd2) begin
                id_idx <= 2'd0;
                if (ID_REPEAT) spi_tx_data <= id_byte(2'd0);
                else           spi_tx_strobe <= 1'b0;
              end else begin
                id_idx      <= id_idx + 2'd1;
                spi_tx_data <= id_byte(id_idx + 2'd1);
              end
            end
            default: ;
          endcase
        end
        if (state == ST_DATA && rd_wait) begin
          if (rd_first) begin
            spi_tx_data   <= mem_rdata;
            spi_tx_strobe <= 1'b1;
          end else begin
            pf_data  <= mem_rdata;
            pf_valid <= 1'b1;
          end
        end
        // Address register always points at the next byte to fetch.
        if (issue_fetch) begin
          mem_rd_en <= 1'b1;
          mem_addr  <= fetch_addr;
          addr      <= fetch_addr + 1'b1;
          mem_first <= (state != ST_DATA);
        end
      end
    end
  end

endmodule
